// File: rtl/cacheline_adaptor_pkg.sv
// Shared LC-3b memory types plus the line/beat geometry used by the cache
// line adaptor.
package cacheline_adaptor_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int WORDS_DEF  = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int LINE_BEATS = 8;

    typedef logic [WORD_W_DEF-1:0]            lc3b_word;
    typedef logic [WORD_W_DEF*WORDS_DEF-1:0]  lc3b_data;
    typedef logic [2:0]                       lc3b_beat;

endpackage

// File: rtl/cacheline_adaptor.sv
// Memory-side responder for the L1 line interface. Each line fill or
// writeback becomes a burst of word accesses on the wmem_* port. The burst
// walks the line's words in ascending order. Every beat waits for wmem_resp.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int WORDS  = WORDS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pmem_read,
    input  logic                     pmem_write,
    input  logic [ADDR_W-1:0]        pmem_address,
    input  logic [WORD_W*WORDS-1:0]  pmem_wdata,
    output logic [WORD_W*WORDS-1:0]  pmem_rdata,
    output logic                     pmem_resp,
    output logic                     wmem_read,
    output logic                     wmem_write,
    output logic [ADDR_W-1:0]        wmem_address,
    output logic [WORD_W-1:0]        wmem_wdata,
    input  logic [WORD_W-1:0]        wmem_rdata,
    input  logic                     wmem_resp
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int OFF_W  = BEAT_W + BYTE_W;
    localparam int TAG_W  = ADDR_W - OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_BEAT = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic [TAG_W-1:0]              tag_q, tag_d;
    // Holds the outgoing line on a writeback and assembles the incoming
    // words on a fill. pmem_rdata is kept separate so that it only changes
    // when a fill completes.
    logic [WORDS-1:0][WORD_W-1:0]  line_q, line_d;
    logic [WORD_W*WORDS-1:0]       rdata_q, rdata_d;

    // Byte and word offset bits of the line address are don't-care.
    logic unused_offset;
    assign unused_offset = ^pmem_address[OFF_W-1:0];

    // State, beat counter, and line/address latches. A reset mid-burst aborts
    // the burst immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            tag_q   <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

    // Next state: accept requests with writeback priority, then step one beat
    // per wmem_resp. The counter wraps back to 0 on the final beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tag_d   = tag_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    tag_d   = pmem_address[ADDR_W-1:OFF_W];
                    line_d  = pmem_wdata;
                    beat_d  = '0;
                    state_d = WR_BEAT;
                end else if (pmem_read) begin
                    tag_d   = pmem_address[ADDR_W-1:OFF_W];
                    beat_d  = '0;
                    state_d = RD_BEAT;
                end
            end
            RD_BEAT: begin
                if (wmem_resp) begin
                    line_d[beat_q] = wmem_rdata;
                    beat_d         = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        rdata_d = line_d;
                        state_d = DONE;
                    end
                end
            end
            WR_BEAT: begin
                if (wmem_resp) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from state. Strobes therefore fall together with the
    // asynchronous reset.
    always_comb begin
        pmem_resp    = (state_q == DONE);
        pmem_rdata   = rdata_q;
        wmem_read    = (state_q == RD_BEAT);
        wmem_write   = (state_q == WR_BEAT);
        wmem_address = {tag_q, beat_q, {BYTE_W{1'b0}}};
        wmem_wdata   = (state_q == WR_BEAT) ? line_q[beat_q] : '0;
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pmem_read, pmem_write;
    logic [15:0]   pmem_address;
    logic [127:0]  pmem_wdata, pmem_rdata;
    logic          pmem_resp;
    logic          wmem_read, wmem_write;
    logic [15:0]   wmem_address, wmem_wdata, wmem_rdata;
    logic          wmem_resp;

    int checks = 0;
    int errors = 0;

    // Word-addressed model of physical memory.
    logic [15:0] mem [int];
    logic [127:0] cur_rdata;
    logic [127:0] fin;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .wmem_read    (wmem_read),
        .wmem_write   (wmem_write),
        .wmem_address (wmem_address),
        .wmem_wdata   (wmem_wdata),
        .wmem_rdata   (wmem_rdata),
        .wmem_resp    (wmem_resp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mrd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a * 16'd7 + 16'h03C1;
    endfunction

    // The line the model memory holds at the line containing address a.
    function automatic logic [127:0] mline(input logic [15:0] a);
        logic [127:0] l;
        logic [15:0]  base;
        base = {a[15:4], 4'h0};
        for (int i = 0; i < 8; i++) l[16*i +: 16] = mrd(base + 16'(2*i));
        return l;
    endfunction

    function automatic int pick(input int waits);
        return (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    endfunction

    // Issues one line request and acts as the word memory until pmem_resp.
    // The bench checks each beat's strobe, address, write data, and the held
    // pmem_rdata. It then checks latency, beat count, and the final line. If
    // abort_at >= 0, the task instead applies reset when that beat is
    // reached.
    task automatic run_txn(input bit rd, input bit wr, input bit keep_rd,
                           input logic [15:0] addr, input logic [127:0] wd,
                           input int waits, input int abort_at,
                           input logic [127:0] hold, output logic [127:0] res);
        int cyc, beat, wleft, tw;
        bit done;
        logic [15:0]  base;
        logic [127:0] exp_line;
        base     = {addr[15:4], 4'h0};
        exp_line = wr ? hold : mline(addr);
        res      = hold;
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        wmem_resp    = 1'($urandom);
        wmem_rdata   = 16'($urandom);
        wleft = pick(waits);
        tw = 0; beat = 0; cyc = 0; done = 0;
        while (!done) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                pmem_address = 16'($urandom);
                pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
            if (cyc > 300) begin
                chk("timeout", 1, 0);
                pmem_read = 0; pmem_write = 0; wmem_resp = 0;
                done = 1;
            end else if (pmem_resp) begin
                chk("latency", cyc, 9 + tw);
                chk("beats", beat, 8);
                chk("done_rdata", pmem_rdata, exp_line);
                chk("done_strobes", {wmem_read, wmem_write}, 2'b00);
                res = pmem_rdata;
                wmem_resp  = 0;
                pmem_write = 0;
                if (!keep_rd) pmem_read = 0;
                @(posedge clk);
                #1;
                chk("resp_one_cycle", pmem_resp, 0);
                done = 1;
            end else begin
                chk("strobe", {wmem_read, wmem_write}, wr ? 2'b01 : 2'b10);
                chk("wmem_addr", wmem_address, base + 16'(2*beat));
                if (wr && beat < 8) chk("wmem_wdata", wmem_wdata, wd[16*beat +: 16]);
                chk("rdata_hold", pmem_rdata, hold);
                if (beat == abort_at) begin
                    reset_n = 0;
                    #1;
                    chk("rst_strobes", {wmem_read, wmem_write}, 2'b00);
                    chk("rst_resp", pmem_resp, 0);
                    chk("rst_rdata", pmem_rdata, 0);
                    chk("rst_addr", wmem_address, 0);
                    pmem_read = 0; pmem_write = 0; wmem_resp = 0;
                    repeat (2) begin
                        @(negedge clk);
                        chk("rst_no_resp", pmem_resp, 0);
                    end
                    reset_n = 1;
                    res = '0;
                    done = 1;
                end else if (wleft > 0) begin
                    wmem_resp  = 0;
                    wmem_rdata = 16'($urandom);
                    wleft--;
                    tw++;
                end else begin
                    wmem_resp = 1;
                    if (wr) begin
                        if (beat < 8) mem[int'(base + 16'(2*beat))] = wd[16*beat +: 16];
                        wmem_rdata = 16'($urandom);
                    end else begin
                        wmem_rdata = mrd(base + 16'(2*beat));
                    end
                    beat++;
                    wleft = pick(waits);
                end
            end
        end
    endtask

    initial begin
        logic [127:0] wd2;
        logic [15:0]  raddr;
        bit           rw;
        reset_n = 0;
        pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
        wmem_rdata = '0; wmem_resp = 0;
        #1;
        chk("reset_resp", pmem_resp, 0);
        chk("reset_rdata", pmem_rdata, 0);
        chk("reset_strobes", {wmem_read, wmem_write}, 2'b00);
        chk("reset_addr", wmem_address, 0);
        chk("reset_wdata", wmem_wdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        cur_rdata = '0;

        // Zero-wait fill whose words are A000 + word index.
        for (int i = 0; i < 8; i++) mem[32'h1230 + 2*i] = 16'hA000 + 16'(i);
        run_txn(1, 0, 0, 16'h1234, '0, 0, -1, cur_rdata, fin);
        chk("t1_line", fin, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
        cur_rdata = fin;

        // Writeback with two wait states per beat (latency 25). The bench
        // then reads the line back.
        wd2 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        run_txn(0, 1, 0, 16'h0F80, wd2, 2, -1, cur_rdata, fin);
        chk("t2_rdata_unchanged", fin, 128'hA007_A006_A005_A004_A003_A002_A001_A000);
        run_txn(1, 0, 0, 16'h0F80, '0, 1, -1, cur_rdata, fin);
        chk("t2_readback", fin, wd2);
        cur_rdata = fin;

        // Both strobes high: the write goes first. The held read follows.
        wd2 = {$urandom, $urandom, $urandom, $urandom};
        run_txn(1, 1, 1, 16'h2000, wd2, -1, -1, cur_rdata, fin);
        run_txn(1, 0, 0, 16'h2000, '0, 0, -1, cur_rdata, fin);
        chk("t3_read_after_write", fin, wd2);
        cur_rdata = fin;

        // Reset at beat 4 of a fill. The retry then restarts at beat 0.
        run_txn(1, 0, 0, 16'h3000, '0, 1, 4, cur_rdata, fin);
        cur_rdata = '0;
        run_txn(1, 0, 0, 16'h3000, '0, -1, -1, cur_rdata, fin);
        cur_rdata = fin;

        // Back-to-back fills. The first line holds until the second completes.
        run_txn(1, 0, 1, 16'h0040, '0, -1, -1, cur_rdata, fin);
        cur_rdata = fin;
        run_txn(1, 0, 0, 16'h0050, '0, -1, -1, cur_rdata, fin);
        chk("t5_second_line", fin, mline(16'h0050));
        cur_rdata = fin;

        // Random mix over a small set of lines so that reads hit earlier
        // writes.
        for (int n = 0; n < 20; n++) begin
            raddr = {4'h5, 5'd0, 3'($urandom), 4'($urandom)};
            rw    = 1'($urandom);
            wd2   = {$urandom, $urandom, $urandom, $urandom};
            if (rw) begin
                run_txn(0, 1, 0, raddr, wd2, -1, -1, cur_rdata, fin);
            end else begin
                run_txn(1, 0, 0, raddr, '0, -1, -1, cur_rdata, fin);
                cur_rdata = fin;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
